// File: rtl/hack_mem_pkg.sv
// Shared constants and types for the Hack data-memory hierarchy.
// RAM4K is built from eight RAM512 banks.
package hack_mem_pkg;

  localparam int unsigned WORD_W        = 16;
  localparam int unsigned RAM4K_ADDR_W  = 12;
  localparam int unsigned RAM512_ADDR_W = 9;
  localparam int unsigned RAM4K_BANKS   = 8;
  localparam int unsigned BANK_SEL_W    = RAM4K_ADDR_W - RAM512_ADDR_W;
  localparam int unsigned RAM512_DEPTH  = 2 ** RAM512_ADDR_W;

  typedef logic [WORD_W-1:0] word_t;

  // 1-of-8 bank decode used for the load DMux.
  function automatic logic [RAM4K_BANKS-1:0] bank_dec(input logic [BANK_SEL_W-1:0] sel);
    logic [RAM4K_BANKS-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/hack_ram4k_if.sv
// Memory-port bundle for hack_ram4k: write data, address, write enable and read data.
interface hack_ram4k_if;
  import hack_mem_pkg::*;

  word_t                   in;
  logic [RAM4K_ADDR_W-1:0] address;
  logic                    load;
  word_t                   out;

  modport master (output in, output address, output load, input out);
  modport slave  (input in, input address, input load, output out);

endinterface

// File: rtl/hack_ram512.sv
// 512 x 16 bank: synchronous write, combinational read, async active-low clear of every word.
module hack_ram512
  import hack_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  word_t                    in,
  input  logic [RAM512_ADDR_W-1:0] address,
  input  logic                     load,
  output word_t                    out
);

  word_t mem [RAM512_DEPTH];

  // Ternary rather than if(load) so an X on load corrupts only the addressed word in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM512_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      mem[address] <= load ? in : mem[address];
    end
  end

  assign out = mem[address];

endmodule

// File: rtl/hack_ram4k.sv
// 4096 x 16 Hack RAM4K: eight RAM512 banks selected by address[11:9].
// Optional macro RAM4K_WRITE_FORWARD_EN forwards `in` to `out` while load is asserted.
module hack_ram4k
  import hack_mem_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  hack_ram4k_if.slave bus
);

  localparam int unsigned WIDTH  = WORD_W;
  localparam int unsigned ADDR_W = RAM4K_ADDR_W;

  logic [BANK_SEL_W-1:0]    sel;
  logic [RAM512_ADDR_W-1:0] offset;
  logic [RAM4K_BANKS-1:0]   bank_load;
  word_t                    bank_out [RAM4K_BANKS];
  logic [WIDTH-1:0]         mem_word;

  assign sel    = bus.address[ADDR_W-1:RAM512_ADDR_W];
  assign offset = bus.address[RAM512_ADDR_W-1:0];

  // AND with the decode keeps an X load confined to the selected bank.
  assign bank_load = {RAM4K_BANKS{bus.load}} & bank_dec(sel);

  for (genvar b = 0; b < RAM4K_BANKS; b++) begin : g_bank
    hack_ram512 u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (bus.in),
      .address (offset),
      .load    (bank_load[b]),
      .out     (bank_out[b])
    );
  end

  assign mem_word = bank_out[sel];

`ifdef RAM4K_WRITE_FORWARD_EN
  assign bus.out = (bus.load && rst_n) ? bus.in : mem_word;
`else
  assign bus.out = mem_word;
`endif

endmodule

// File: tb/tb_hack_ram4k.sv
// Scoreboard bench for hack_ram4k: stimulus queues expected reads, a monitor compares bus.out.
module tb_hack_ram4k;
  import hack_mem_pkg::*;

  typedef struct {
    word_t v;
    string name;
  } exp_t;

  logic clk;
  logic rst_n;
  hack_ram4k_if bus ();

  hack_ram4k dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  event chk_ev;
  int   total = 0;
  int   bad   = 0;

  // Monitor: each strobe marks a point where bus.out is valid for the queued expectation.
  initial begin
    forever begin
      @(chk_ev);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monitor_underflow: got=%h expected=<queued value>", bus.out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (bus.out !== e.v) begin
          bad++;
          $display("FAIL %s: addr=%h got=%h expected=%h", e.name, bus.address, bus.out, e.v);
        end
      end
    end
  end

  task automatic expect_at(input logic [RAM4K_ADDR_W-1:0] a, input word_t v, input string name);
    exp_t e;
    bus.address = a;
    #1;
    e.v    = v;
    e.name = name;
    exp_q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  // Write on the next rising edge; returns 1ns after that edge with load cleared.
  task automatic wr(input logic [RAM4K_ADDR_W-1:0] a, input word_t d);
    @(negedge clk);
    bus.address = a;
    bus.in      = d;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.in      = '0;
    bus.address = '0;
    bus.load    = 1'b0;
    #12;
    rst_n = 1'b1;
    expect_at(12'h000, 16'h0000, "por_000");
    expect_at(12'hFFF, 16'h0000, "por_fff");

    // Asynchronous reset pulse between edges.
    wr(12'h000, 16'h3333);
    wr(12'h7FF, 16'h2222);
    wr(12'hFFF, 16'h1111);
    expect_at(12'h7FF, 16'h2222, "pre_reset_7ff");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    expect_at(12'h000, 16'h0000, "async_rst_000");
    rst_n = 1'b1;
    expect_at(12'h7FF, 16'h0000, "async_rst_7ff");
    expect_at(12'hFFF, 16'h0000, "async_rst_fff");

    // Full sweep: write, hold, clear.
    for (int a = 0; a < 4096; a++) begin
      wr(a[11:0], a[15:0]);
      expect_at(a[11:0], a[15:0], "sweep_write");
      @(negedge clk);
      bus.in = '0;
      @(posedge clk);
      #1;
      expect_at(a[11:0], a[15:0], "sweep_hold");
      wr(a[11:0], 16'h0000);
      expect_at(a[11:0], 16'h0000, "sweep_zero");
    end

    // Isolation across banks.
    wr(12'h000, 16'h1234);
    wr(12'h200, 16'hBEEF);
    expect_at(12'h000, 16'h1234, "iso_000");
    expect_at(12'h200, 16'hBEEF, "iso_200");
    expect_at(12'h001, 16'h0000, "iso_001");

    // Combinational read with no clock edge between address changes.
    wr(12'hFFF, 16'hAAAA);
    wr(12'h001, 16'h5555);
    @(negedge clk);
    expect_at(12'hFFF, 16'hAAAA, "comb_fff_a");
    expect_at(12'h001, 16'h5555, "comb_001_a");
    @(negedge clk);
    expect_at(12'hFFF, 16'hAAAA, "comb_fff_b");
    expect_at(12'h001, 16'h5555, "comb_001_b");

    // Back-to-back writes to one address.
    wr(12'h300, 16'h0001);
    wr(12'h300, 16'h0002);
    expect_at(12'h300, 16'h0002, "b2b_last_wins");

    // Reset held across a write edge.
    @(negedge clk);
    rst_n       = 1'b0;
    bus.address = 12'h123;
    bus.in      = 16'hFFFF;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    rst_n    = 1'b1;
    expect_at(12'h123, 16'h0000, "rst_beats_write");
    expect_at(12'h300, 16'h0000, "rst_clears_300");
    wr(12'h123, 16'hFFFF);
    expect_at(12'h123, 16'hFFFF, "first_write_after_rst");

    // Read-during-write: before and after the edge.
    wr(12'h050, 16'h0F0F);
    @(negedge clk);
    bus.address = 12'h050;
    bus.in      = 16'h00C3;
    bus.load    = 1'b1;
`ifdef RAM4K_WRITE_FORWARD_EN
    expect_at(12'h050, 16'h00C3, "rdw_before_edge_fwd");
`else
    expect_at(12'h050, 16'h0F0F, "rdw_before_edge_old");
`endif
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    expect_at(12'h050, 16'h00C3, "rdw_after_edge");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
